// File: rtl/regfile24_flags.sv
// regfile24_flags: 8x24 operand register file with write bypass and ALU status-flag register.
// Ports: Clock/Reset_n (sync, active-low); RegWrite/WriteReg/WriteData write port;
// ReadReg1/ReadReg2 -> ReadData1/ReadData2 combinational read ports;
// FlagWrite/ZeroIn/OverflowIn/CarryIn -> ZeroFlag/OverflowFlag/CarryFlag registered flags.
module regfile24_flags #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  FlagWrite,
    input  logic                  ZeroIn,
    input  logic                  OverflowIn,
    input  logic                  CarryIn,
    output logic                  ZeroFlag,
    output logic                  OverflowFlag,
    output logic                  CarryFlag
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [2:0]            flags_q, flags_d;
    logic                  wr_hit;

    // A write that will land this edge; R0 writes and writes under reset never land.
    assign wr_hit = Reset_n && RegWrite && (WriteReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[WriteReg] = WriteData;
        regs_d[0] = '0;
        if (!Reset_n) regs_d = '{default: '0};
        flags_d = !Reset_n ? 3'b000 : FlagWrite ? {ZeroIn, OverflowIn, CarryIn} : flags_q;
    end

    always_ff @(posedge Clock) begin
        regs_q  <= regs_d;
        flags_q <= flags_d;
    end

    assign ReadData1 = (wr_hit && WriteReg == ReadReg1) ? WriteData : regs_q[ReadReg1];
    assign ReadData2 = (wr_hit && WriteReg == ReadReg2) ? WriteData : regs_q[ReadReg2];
    assign {ZeroFlag, OverflowFlag, CarryFlag} = flags_q;
endmodule

// File: tb/tb_regfile24_flags.sv
// tb_regfile24_flags: scoreboard bench for regfile24_flags.
module tb_regfile24_flags;
    logic        Clock = 0;
    logic        Reset_n = 0;
    logic        RegWrite = 0;
    logic [2:0]  WriteReg = 0;
    logic [23:0] WriteData = 0;
    logic [2:0]  ReadReg1 = 0;
    logic [2:0]  ReadReg2 = 0;
    logic [23:0] ReadData1, ReadData2;
    logic        FlagWrite = 0;
    logic        ZeroIn = 0, OverflowIn = 0, CarryIn = 0;
    logic        ZeroFlag, OverflowFlag, CarryFlag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [23:0] rd1;
        logic [23:0] rd2;
        logic [2:0]  fl;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] mdl [8];
    logic [2:0]  mfl;

    regfile24_flags dut (
        .Clock(Clock), .Reset_n(Reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .FlagWrite(FlagWrite),
        .ZeroIn(ZeroIn), .OverflowIn(OverflowIn), .CarryIn(CarryIn),
        .ZeroFlag(ZeroFlag), .OverflowFlag(OverflowFlag), .CarryFlag(CarryFlag)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push expected combinational reads and current flags, then advance the model.
    task automatic cyc(input string tag, input logic rn, input logic we, input logic [2:0] wa,
                       input logic [23:0] wd, input logic [2:0] a1, input logic [2:0] a2,
                       input logic fw, input logic [2:0] fin, input bit sb);
        exp_t e;
        logic byp;
        @(posedge Clock);
        #1;
        Reset_n = rn; RegWrite = we; WriteReg = wa; WriteData = wd;
        ReadReg1 = a1; ReadReg2 = a2; FlagWrite = fw;
        {ZeroIn, OverflowIn, CarryIn} = fin;
        byp = rn && we && (wa != 0);
        e.tag = tag;
        e.rd1 = (a1 == 0) ? 24'h0 : (byp && wa == a1) ? wd : mdl[a1];
        e.rd2 = (a2 == 0) ? 24'h0 : (byp && wa == a2) ? wd : mdl[a2];
        e.fl  = mfl;
        if (sb) sbq.push_back(e);
        if (!rn) begin
            foreach (mdl[i]) mdl[i] = 24'h0;
            mfl = 3'b000;
        end else begin
            if (byp) mdl[wa] = wd;
            if (fw) mfl = fin;
        end
    endtask

    always @(negedge Clock) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check({e.tag, ".rd1"}, ReadData1, e.rd1);
            check({e.tag, ".rd2"}, ReadData2, e.rd2);
            check({e.tag, ".flags"}, {21'h0, ZeroFlag, OverflowFlag, CarryFlag}, {21'h0, e.fl});
        end
    end

    initial begin
        foreach (mdl[i]) mdl[i] = 24'h0;
        mfl = 3'b000;
        cyc("init_rst", 0, 0, 0, 24'h0, 0, 0, 0, 3'b000, 0);
        cyc("post_rst", 1, 0, 0, 24'h0, 1, 7, 0, 3'b000, 1);
        for (int i = 1; i < 8; i++)
            cyc("fill", 1, 1, i[2:0], 24'hABCDEF, i[2:0], 3'(i - 1), 1, 3'b111, 1);
        cyc("rst_prio", 0, 1, 4, 24'h0F0F0F, 4, 4, 1, 3'b100, 1);
        for (int i = 0; i < 8; i += 2)
            cyc("rst_clear", 1, 0, 0, 24'h0, i[2:0], 3'(i + 1), 0, 3'b000, 1);
        cyc("wr3_byp", 1, 1, 3, 24'h123456, 3, 1, 0, 3'b000, 1);
        cyc("rd3", 1, 0, 0, 24'h0, 3, 3, 0, 3'b000, 1);
        cyc("wr0", 1, 1, 0, 24'hFFFFFF, 0, 0, 0, 3'b000, 1);
        cyc("rd0", 1, 0, 0, 24'h0, 0, 0, 0, 3'b000, 1);
        cyc("wr5", 1, 1, 5, 24'h000001, 0, 0, 0, 3'b000, 1);
        cyc("rd5_nowr", 1, 0, 5, 24'h7FFFFF, 5, 5, 0, 3'b000, 1);
        cyc("byp5_both", 1, 1, 5, 24'h7FFFFF, 5, 5, 0, 3'b000, 1);
        cyc("rd5_after", 1, 0, 0, 24'h0, 5, 5, 0, 3'b000, 1);
        cyc("wr1", 1, 1, 1, 24'h7FFFFF, 0, 0, 0, 3'b000, 1);
        cyc("wr2", 1, 1, 2, 24'h000001, 0, 0, 0, 3'b000, 1);
        cyc("alu_add", 1, 1, 3, 24'h800000, 1, 2, 1, 3'b010, 1);
        cyc("alu_wb", 1, 0, 0, 24'h0, 3, 1, 0, 3'b000, 1);
        for (int i = 0; i < 5; i++)
            cyc("flag_hold", 1, 0, 0, 24'h0, 3, 2, 0, 3'($urandom_range(0, 7)), 1);
        cyc("flag_set", 1, 0, 0, 24'h0, 1, 2, 1, 3'b111, 1);
        cyc("rst_prio2", 0, 1, 4, 24'h0F0F0F, 4, 3, 1, 3'b100, 1);
        cyc("after_rst", 1, 0, 0, 24'h0, 4, 3, 0, 3'b000, 1);
        for (int i = 0; i < 60; i++)
            cyc("rand", ($urandom_range(0, 15) != 0), 1'($urandom), 3'($urandom), 24'($urandom),
                3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1);
        @(posedge Clock);
        #6;
        check("sb_drained", 24'(sbq.size()), 24'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile24_flags.md
# regfile24_flags

Operand register file and status-flag register for the 24-bit CPU datapath. It sits directly upstream of the 24-bit ALU: its two read ports drive the ALU's A and B operands. It is also the ALU's write-back target, capturing the ALU result and the Zero/Overflow/Carryout flags at the clock edge. Read ports include same-cycle write bypass, so a back-to-back dependent ALU operation sees the value being written.

## Interface
Parameters:
- DATA_WIDTH, 24, register and data-port width; matches the ALU operand width.
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH (8).

Ports:
- Clock  in  1  rising-edge clock; single clock domain.
- Reset_n  in  1  reset, synchronous, active-low; sampled on the rising edge of Clock.
- RegWrite  in  1  write enable for the register array.
- WriteReg  in  ADDR_WIDTH  destination register index.
- WriteData  in  DATA_WIDTH  write-back value (ALU Result or load data, selected outside this block).
- ReadReg1  in  ADDR_WIDTH  source index for port 1 (to ALU A24).
- ReadReg2  in  ADDR_WIDTH  source index for port 2 (to ALU B24).
- ReadData1  out  DATA_WIDTH  port 1 data.
- ReadData2  out  DATA_WIDTH  port 2 data.
- FlagWrite  in  1  enable for flag capture.
- ZeroIn  in  1  ALU Zero.
- OverflowIn  in  1  ALU Overflow.
- CarryIn  in  1  ALU Carryout.
- ZeroFlag  out  1  registered Zero.
- OverflowFlag  out  1  registered Overflow.
- CarryFlag  out  1  registered Carry.

## Operation
- Array: NUM_REGS x DATA_WIDTH flops. R0 is hardwired to 0.
  - Writes to R0 are discarded.
  - Reads of R0 return 0, including under bypass.
- Write: at the rising edge, if Reset_n=1 and RegWrite=1 and WriteReg!=0, then R[WriteReg] <= WriteData.
- Read: ReadDataN is combinational from ReadRegN.
- Bypass: if RegWrite=1, WriteReg==ReadRegN and WriteReg!=0, then ReadDataN = WriteData in the same cycle. Otherwise ReadDataN = R[ReadRegN].
  - Both ports bypass independently.
  - ReadReg1==ReadReg2==WriteReg bypasses on both ports.
- Flags: at the rising edge, if Reset_n=1 and FlagWrite=1, then {ZeroFlag, OverflowFlag, CarryFlag} <= {ZeroIn, OverflowIn, CarryIn}. Otherwise they hold.
- RegWrite and FlagWrite are independent. Both may be active in the same cycle.
- Reset:
  - At a rising edge with Reset_n=0, all registers R1..R7 and all three flags become 0.
  - Reset has priority over a simultaneous RegWrite or FlagWrite; the write is lost.
  - Bypass is suppressed while Reset_n=0, so ReadDataN shows array contents.
- Reset asserted mid-sequence: the in-flight write is dropped and the state is fully cleared on that edge. The first write after reset release takes effect on the first edge with Reset_n=1.
- No X propagation: every index in range 0..NUM_REGS-1 is valid. There are no out-of-range addresses.

## Timing
- Write latency: 1 cycle to the array. Bypass gives 0-cycle visibility on the read ports.
- Read path: purely combinational address -> data. No output register.
- Flag latency: flags are visible on outputs 1 cycle after the FlagWrite edge.
- Reset values:
  - ReadData1/ReadData2 = 0 for any address after reset (array cleared).
  - ZeroFlag = OverflowFlag = CarryFlag = 0.
- Only the flags and the array are sequential. No handshake; every enabled write completes in one edge.

## Test plan
- Reset clear: write 24'hABCDEF to R1..R7, hold Reset_n=0 for one edge -> all reads return 24'h000000 and all flags = 0.
- Write/read with R0 guard:
  - RegWrite=1, WriteReg=3, WriteData=24'h123456 -> next cycle ReadReg1=3 gives 24'h123456.
  - RegWrite=1, WriteReg=0, WriteData=24'hFFFFFF -> ReadReg2=0 gives 0, both same-cycle and next cycle.
- Bypass:
  - R5=24'h000001. In the same cycle: RegWrite=1, WriteReg=5, WriteData=24'h7FFFFF, ReadReg1=ReadReg2=5 -> both ports show 24'h7FFFFF before the edge.
  - With RegWrite=0 -> both ports show 24'h000001.
- ALU loop: R1=24'h7FFFFF, R2=24'h000001, ALU add with FlagWrite=1 -> OverflowFlag=1, CarryFlag=0, ZeroFlag=0 next cycle. Write-back of 24'h800000 to R3 is readable next cycle.
- Flag hold: FlagWrite=0 while ZeroIn/OverflowIn/CarryIn toggle for 5 cycles -> the flags keep their previous values.
- Reset priority: Reset_n=0 with RegWrite=1 (WriteReg=4, WriteData=24'h0F0F0F) and FlagWrite=1 (ZeroIn=1) on the same edge -> R4=0 and ZeroFlag=0 after the edge.
